// File: rtl/onion_timer_multi.sv
// Multi-channel period timer: shared prescaler, per-channel one-shot/periodic counters,
// sticky expiry flags and a masked interrupt. Define ONION_TIMER_CHAIN_EN to enable channel cascading.
module onion_timer_multi #(
   parameter int WIDTH      = 32,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH*WIDTH-1:0]   period_i,
   input  logic [NUM_CH-1:0]         enable_i,
   input  logic [NUM_CH-1:0]         mode_i,
   input  logic [NUM_CH-1:0]         restart_i,
   input  logic [NUM_CH-1:0]         status_clr_i,
   input  logic [NUM_CH-1:0]         irq_en_i,
   input  logic [NUM_CH-1:0]         chain_i,
   input  logic [PRESCALE_W-1:0]     prescale_i,
   output logic [NUM_CH*WIDTH-1:0]   count_o,
   output logic [NUM_CH-1:0]         tick_o,
   output logic [NUM_CH-1:0]         expired_o,
   output logic                      irq_o,
   output logic                      dbg_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q   [NUM_CH];
   state_t                  state_d   [NUM_CH];
   logic [WIDTH-1:0]        count_q   [NUM_CH];
   logic [WIDTH-1:0]        count_d   [NUM_CH];
   logic [PRESCALE_W-1:0]   pre_ctr_q;
   logic [PRESCALE_W-1:0]   pre_ctr_d;
   logic [NUM_CH-1:0]       tick_q;
   logic [NUM_CH-1:0]       expired_q;
   logic [NUM_CH-1:0]       expired_d;
   logic                    irq_q;
   logic                    irq_d;
   logic                    any_en_s;
   logic                    tick_en_s;
   logic [NUM_CH-1:0]       adv_s;
   logic [NUM_CH-1:0]       expire_s;

`ifdef ONION_TIMER_CHAIN_EN
   logic                    chain_prev_s;
`else
   logic                    unused_chain_s;
   assign unused_chain_s = ^chain_i;
`endif

   // Shared prescaler; >= compare lets a lowered prescale_i wrap immediately.
   always_comb begin
      any_en_s  = |enable_i;
      tick_en_s = any_en_s && (pre_ctr_q >= prescale_i);
      if (!any_en_s) begin
         pre_ctr_d = {PRESCALE_W{1'b0}};
      end else if (tick_en_s) begin
         pre_ctr_d = {PRESCALE_W{1'b0}};
      end else begin
         pre_ctr_d = pre_ctr_q + PRESCALE_W'(1'b1);
      end
   end

   // Per-channel FSM: enable=0 beats restart, restart beats expiry, expiry beats increment.
   always_comb begin
      expire_s = {NUM_CH{1'b0}};
      adv_s    = {NUM_CH{1'b0}};
`ifdef ONION_TIMER_CHAIN_EN
      chain_prev_s = 1'b0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         state_d[k] = state_q[k];
         count_d[k] = count_q[k];
`ifdef ONION_TIMER_CHAIN_EN
         // A chained channel counts expiries of its lower neighbour instead of prescaler ticks.
         if ((k != 0) && chain_i[k]) begin
            adv_s[k] = chain_prev_s;
         end else begin
            adv_s[k] = tick_en_s;
         end
`else
         adv_s[k] = tick_en_s;
`endif
         if (!enable_i[k]) begin
            state_d[k] = ST_IDLE;
            count_d[k] = {WIDTH{1'b0}};
         end else begin
            case (state_q[k])
               ST_IDLE: begin
                  state_d[k] = ST_RUN;
                  count_d[k] = {WIDTH{1'b0}};
               end
               ST_RUN: begin
                  if (restart_i[k]) begin
                     count_d[k] = {WIDTH{1'b0}};
                  end else if (adv_s[k]) begin
                     if (count_q[k] >= period_i[k*WIDTH +: WIDTH]) begin
                        expire_s[k] = 1'b1;
                        if (mode_i[k]) begin
                           count_d[k] = {WIDTH{1'b0}};
                        end else begin
                           state_d[k] = ST_DONE;
                        end
                     end else begin
                        count_d[k] = count_q[k] + WIDTH'(1'b1);
                     end
                  end else begin
                     count_d[k] = count_q[k];
                  end
               end
               ST_DONE: begin
                  if (restart_i[k]) begin
                     state_d[k] = ST_RUN;
                     count_d[k] = {WIDTH{1'b0}};
                  end else begin
                     state_d[k] = ST_DONE;
                  end
               end
               default: begin
                  state_d[k] = ST_IDLE;
                  count_d[k] = {WIDTH{1'b0}};
               end
            endcase
         end
`ifdef ONION_TIMER_CHAIN_EN
         chain_prev_s = expire_s[k];
`endif
      end
   end

   // Sticky status (set wins over clear) and registered interrupt.
   always_comb begin
      expired_d = expire_s | (expired_q & ~status_clr_i);
      irq_d     = |(expired_q & irq_en_i);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_ctr_q <= {PRESCALE_W{1'b0}};
         tick_q    <= {NUM_CH{1'b0}};
         expired_q <= {NUM_CH{1'b0}};
         irq_q     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= ST_IDLE;
            count_q[k] <= {WIDTH{1'b0}};
         end
      end else begin
         pre_ctr_q <= pre_ctr_d;
         tick_q    <= expire_s;
         expired_q <= expired_d;
         irq_q     <= irq_d;
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= state_d[k];
            count_q[k] <= count_d[k];
         end
      end
   end

   // Flatten counters onto the output bus.
   always_comb begin
      count_o = {(NUM_CH*WIDTH){1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         count_o[k*WIDTH +: WIDTH] = count_q[k];
      end
   end

   assign tick_o    = tick_q;
   assign expired_o = expired_q;
   assign irq_o     = irq_q;
   assign dbg_o     = tick_q[0];

endmodule
